// File: rtl/min_receive_fsm.sv
// rtl/min_receive_fsm.sv - MIN frame receiver: header sync, byte unstuffing, length/CRC/EOF checks.
// Optional CRC32 checking is built only when MIN_RX_CRC_CHECK_EN is defined.
module min_receive_fsm #(
  parameter int N_DATA_BYTE = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic [7:0]               i_data,
  output logic                     o_valid,
  output logic [7:0]               o_id,
  output logic [8*N_DATA_BYTE-1:0] o_data,
  output logic                     o_crc_err,
  output logic                     o_frame_err,
  output logic                     o_busy
);

  localparam int PW   = 8 * N_DATA_BYTE;
  localparam int MAXC = (N_DATA_BYTE > 4) ? N_DATA_BYTE : 4;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    ST_HDR,
    ST_ID,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC,
    ST_EOF
  } state_t;

  state_t        state;
  logic [1:0]    aa_cnt;
  logic [CW-1:0] byte_cnt;
  logic          len_bad;
  logic [7:0]    id_q;
  logic [PW-1:0] payload_q;
  logic          accept;
  logic          is_aa;
  logic          crc_good;

  assign accept = i_valid & i_en;
  assign is_aa  = (i_data == 8'hAA);
  assign o_busy = (state != ST_HDR);

`ifdef MIN_RX_CRC_CHECK_EN
  logic [31:0] crc_acc;
  logic [31:0] rx_crc;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_good = ((crc_acc ^ 32'hFFFFFFFF) == rx_crc);
`else
  assign crc_good = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_HDR;
      aa_cnt      <= '0;
      byte_cnt    <= '0;
      len_bad     <= 1'b0;
      id_q        <= '0;
      payload_q   <= '0;
      o_valid     <= 1'b0;
      o_crc_err   <= 1'b0;
      o_frame_err <= 1'b0;
      o_id        <= '0;
      o_data      <= '0;
`ifdef MIN_RX_CRC_CHECK_EN
      crc_acc     <= 32'hFFFFFFFF;
      rx_crc      <= '0;
`endif
    end else begin
      o_valid     <= 1'b0;
      o_crc_err   <= 1'b0;
      o_frame_err <= 1'b0;
      if (accept) begin
        if (state == ST_HDR) begin
          if (!is_aa) begin
            aa_cnt <= '0;
          end else if (aa_cnt == 2'd2) begin
            state    <= ST_ID;
            aa_cnt   <= '0;
            byte_cnt <= '0;
            len_bad  <= 1'b0;
`ifdef MIN_RX_CRC_CHECK_EN
            crc_acc  <= 32'hFFFFFFFF;
`endif
          end else begin
            aa_cnt <= aa_cnt + 2'd1;
          end
        end else if (state == ST_EOF) begin
          if (i_data != 8'h55) begin
            o_frame_err <= 1'b1;
          end else if (crc_good) begin
            o_valid <= 1'b1;
            o_id    <= id_q;
            o_data  <= payload_q;
          end else begin
            o_crc_err <= 1'b1;
          end
          state  <= ST_HDR;
          aa_cnt <= '0;
        end else if (aa_cnt == 2'd2) begin
          // Byte after two raw 0xAA in the body: stuff byte, header restart or corruption.
          aa_cnt <= '0;
          if (is_aa) begin
            state    <= ST_ID;
            byte_cnt <= '0;
            len_bad  <= 1'b0;
`ifdef MIN_RX_CRC_CHECK_EN
            crc_acc  <= 32'hFFFFFFFF;
`endif
          end else if (i_data != 8'h55 || len_bad) begin
            o_frame_err <= 1'b1;
            state       <= ST_HDR;
            len_bad     <= 1'b0;
          end else if (state == ST_CRC && byte_cnt == CW'(4)) begin
            state <= ST_EOF;
          end
        end else begin
          aa_cnt <= is_aa ? aa_cnt + 2'd1 : 2'd0;
          case (state)
            ST_ID: begin
              id_q  <= i_data;
              state <= ST_LEN;
`ifdef MIN_RX_CRC_CHECK_EN
              crc_acc <= crc32_byte(crc_acc, i_data);
`endif
            end
            ST_LEN: begin
              // A bad 0xAA length is held back: it may be the start of a restart header.
              if (len_bad || i_data != 8'(N_DATA_BYTE)) begin
                if (is_aa) begin
                  len_bad <= 1'b1;
                end else begin
                  o_frame_err <= 1'b1;
                  state       <= ST_HDR;
                  len_bad     <= 1'b0;
                  aa_cnt      <= '0;
                end
              end else begin
                state    <= ST_PAYLOAD;
                byte_cnt <= '0;
`ifdef MIN_RX_CRC_CHECK_EN
                crc_acc  <= crc32_byte(crc_acc, i_data);
`endif
              end
            end
            ST_PAYLOAD: begin
              payload_q <= PW'({payload_q, i_data});
`ifdef MIN_RX_CRC_CHECK_EN
              crc_acc   <= crc32_byte(crc_acc, i_data);
`endif
              if (byte_cnt == CW'(N_DATA_BYTE - 1)) begin
                byte_cnt <= '0;
                state    <= ST_CRC;
              end else begin
                byte_cnt <= byte_cnt + CW'(1);
              end
            end
            ST_CRC: begin
`ifdef MIN_RX_CRC_CHECK_EN
              rx_crc <= {rx_crc[23:0], i_data};
`endif
              // If the CRC ends in AA AA, wait for its stuff byte before EOF.
              if (byte_cnt == CW'(3)) begin
                if (is_aa && aa_cnt == 2'd1) begin
                  byte_cnt <= CW'(4);
                end else begin
                  state <= ST_EOF;
                end
              end else begin
                byte_cnt <= byte_cnt + CW'(1);
              end
            end
            default: state <= ST_HDR;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_min_receive_fsm.sv
// tb/tb_min_receive_fsm.sv - directed-vector bench for min_receive_fsm with a bit-serial CRC32 model.
module tb_min_receive_fsm;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_en;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        o_valid;
  logic [7:0]  o_id;
  logic [31:0] o_data;
  logic        o_crc_err;
  logic        o_frame_err;
  logic        o_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_vld    = 0;
  int n_crc    = 0;
  int n_ferr   = 0;
  int n_multi  = 0;
  int v0, c0, f0;

  always #5 i_clk = ~i_clk;

  min_receive_fsm #(.N_DATA_BYTE(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .o_id        (o_id),
    .o_data      (o_data),
    .o_crc_err   (o_crc_err),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always @(negedge i_clk) begin
    if (o_valid)     n_vld++;
    if (o_crc_err)   n_crc++;
    if (o_frame_err) n_ferr++;
    if (int'(o_valid) + int'(o_crc_err) + int'(o_frame_err) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] crc32_model(input logic [7:0] q[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic send(input logic [7:0] b);
    i_valid = 1'b1;
    i_data  = b;
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [31:0] pl, input logic [7:0] crc_x,
                            input logic [7:0] eof, input int stall_at);
    logic [7:0]  body[$];
    logic [7:0]  wire_q[$];
    logic [31:0] crc;
    int          run;
    body = {id, 8'h04, pl[31:24], pl[23:16], pl[15:8], pl[7:0]};
    crc  = crc32_model(body) ^ {24'd0, crc_x};
    body.push_back(crc[31:24]);
    body.push_back(crc[23:16]);
    body.push_back(crc[15:8]);
    body.push_back(crc[7:0]);
    wire_q = {8'hAA, 8'hAA, 8'hAA};
    run = 0;
    foreach (body[k]) begin
      wire_q.push_back(body[k]);
      run = (body[k] == 8'hAA) ? run + 1 : 0;
      if (run == 2) begin
        wire_q.push_back(8'h55);
        run = 0;
      end
    end
    wire_q.push_back(eof);
    foreach (wire_q[k]) begin
      if (k == stall_at) begin
        i_en    = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h00;
        repeat (3) @(negedge i_clk);
        check("stall_busy", o_busy, 1'b1);
        i_en = 1'b1;
      end
      send(wire_q[k]);
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_en    = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(negedge i_clk);
    check("rst_valid", o_valid, 1'b0);
    check("rst_crc_err", o_crc_err, 1'b0);
    check("rst_frame_err", o_frame_err, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_id", o_id, 8'h00);
    check("rst_data", o_data, 32'h0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    send_frame(8'h01, 32'h12345678, 8'h00, 8'h55, -1);
    check("basic_valid", o_valid, 1'b1);
    check("basic_id", o_id, 8'h01);
    check("basic_data", o_data, 32'h12345678);
    idle(1);
    check("basic_pulse_end", o_valid, 1'b0);
    check("basic_idle_busy", o_busy, 1'b0);

    send_frame(8'h03, 32'hAAAA55AA, 8'h00, 8'h55, -1);
    check("stuff_valid", o_valid, 1'b1);
    check("stuff_data", o_data, 32'hAAAA55AA);
    idle(2);

    send_frame(8'h05, 32'h12345678, 8'h01, 8'h55, -1);
`ifdef MIN_RX_CRC_CHECK_EN
    check("badcrc_err", o_crc_err, 1'b1);
    check("badcrc_valid", o_valid, 1'b0);
    check("badcrc_data_held", o_data, 32'hAAAA55AA);
    check("badcrc_id_held", o_id, 8'h03);
`else
    check("nocrc_valid", o_valid, 1'b1);
    check("nocrc_err", o_crc_err, 1'b0);
    check("nocrc_id", o_id, 8'h05);
    check("nocrc_data", o_data, 32'h12345678);
`endif
    idle(2);

    send(8'hAA); send(8'hAA); send(8'hAA); send(8'h07); send(8'h03);
    check("len_err", o_frame_err, 1'b1);
    send_frame(8'h08, 32'hDEADBEEF, 8'h00, 8'h55, -1);
    check("after_len_valid", o_valid, 1'b1);
    check("after_len_id", o_id, 8'h08);
    idle(2);

    c0 = n_crc; f0 = n_ferr;
    send(8'hAA); send(8'hAA); send(8'hAA); send(8'h01);
    send_frame(8'h02, 32'hCAFEF00D, 8'h00, 8'h55, -1);
    check("restart_valid", o_valid, 1'b1);
    check("restart_id", o_id, 8'h02);
    idle(2);
    check("restart_no_ferr", n_ferr - f0, 0);
    check("restart_no_crc", n_crc - c0, 0);

    v0 = n_vld; c0 = n_crc; f0 = n_ferr;
    send(8'hAA); send(8'hAA); send(8'hAA); send(8'h09); send(8'h04);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_id", o_id, 8'h00);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    send_frame(8'h0A, 32'h01020304, 8'h00, 8'h55, -1);
    idle(2);
    check("midrst_one_valid", n_vld - v0, 1);
    check("midrst_no_ferr", n_ferr - f0, 0);
    check("midrst_no_crc", n_crc - c0, 0);
    check("midrst_id_new", o_id, 8'h0A);

    send_frame(8'h0B, 32'h55667788, 8'h00, 8'h55, 6);
    check("stall_valid", o_valid, 1'b1);
    check("stall_data", o_data, 32'h55667788);
    idle(2);

    send_frame(8'h0C, 32'h0BADF00D, 8'h00, 8'h56, -1);
    check("eof_err", o_frame_err, 1'b1);
    check("eof_no_valid", o_valid, 1'b0);
    check("eof_data_held", o_data, 32'h55667788);
    idle(2);

    check("one_hot_pulses", n_multi, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
